// File: rtl/key_mode_debouncer.sv
// Push-button conditioner: synchronise, tick-sample and debounce active-low keys,
// then derive press/release/hold pulses and press-toggled state bits.
module key_mode_debouncer #(
  parameter int                NKEYS       = 4,
  parameter int                DIV         = 1024,
  parameter int                DEPTH       = 4,
  parameter int                HOLD_TICKS  = 1000,
  parameter logic [NKEYS-1:0]  TOGGLE_INIT = {NKEYS{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] key,
  output logic [NKEYS-1:0] key_down,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic [NKEYS-1:0] key_hold,
  output logic [NKEYS-1:0] key_toggle,
  output logic             tick
);

  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TICKS);

  logic [NKEYS-1:0]  key_s1_q, key_s_q;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              tick_q, tick_d;
  logic [DEPTH-1:0]  hist_q [NKEYS];
  logic [DEPTH-1:0]  hist_d [NKEYS];
  logic [HOLD_W-1:0] hcnt_q [NKEYS];
  logic [HOLD_W-1:0] hcnt_d [NKEYS];
  logic [NKEYS-1:0]  down_q, down_d;
  logic [NKEYS-1:0]  press_q, press_d;
  logic [NKEYS-1:0]  release_q, release_d;
  logic [NKEYS-1:0]  hold_q, hold_d;
  logic [NKEYS-1:0]  toggle_q, toggle_d;

  always_comb begin
    div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    tick_d    = (div_q == DIV_LAST);
    down_d    = down_q;
    press_d   = '0;
    release_d = '0;
    hold_d    = '0;
    toggle_d  = toggle_q;
    for (int i = 0; i < NKEYS; i++) begin
      hist_d[i] = hist_q[i];
      hcnt_d[i] = hcnt_q[i];
      if (tick_q) begin
        hist_d[i] = {hist_q[i][DEPTH-2:0], key_s_q[i]};
        // Keys are active-low: a full history of zeros means held down.
        if (hist_d[i] == '0)
          down_d[i] = 1'b1;
        else if (&hist_d[i])
          down_d[i] = 1'b0;

        if (down_d[i] && !down_q[i]) begin
          press_d[i]  = 1'b1;
          toggle_d[i] = ~toggle_q[i];
          hcnt_d[i]   = '0;
        end else if (!down_d[i] && down_q[i]) begin
          release_d[i] = 1'b1;
          hcnt_d[i]    = '0;
        end else if (down_q[i] && hcnt_q[i] != HOLD_MAX) begin
          hcnt_d[i] = hcnt_q[i] + 1'b1;
          hold_d[i] = (hcnt_d[i] == HOLD_MAX);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_s1_q  <= '1;
      key_s_q   <= '1;
      div_q     <= '0;
      tick_q    <= 1'b0;
      down_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
      hold_q    <= '0;
      toggle_q  <= TOGGLE_INIT;
      for (int i = 0; i < NKEYS; i++) begin
        hist_q[i] <= '1;
        hcnt_q[i] <= '0;
      end
    end else begin
      key_s1_q  <= key;
      key_s_q   <= key_s1_q;
      div_q     <= div_d;
      tick_q    <= tick_d;
      down_q    <= down_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      toggle_q  <= toggle_d;
      for (int i = 0; i < NKEYS; i++) begin
        hist_q[i] <= hist_d[i];
        hcnt_q[i] <= hcnt_d[i];
      end
    end
  end

  assign key_down    = down_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_hold    = hold_q;
  assign key_toggle  = toggle_q;
  assign tick        = tick_q;

endmodule
